// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the iterative M-extension unit: funct3 opcodes,
// FSM state encoding and opcode-class helper.
package alu_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Divide-class ops (DIV/DIVU/REM/REMU) all have funct3[2] set.
  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction

endpackage

// File: rtl/alu_muldiv_step.sv
// One iteration of the unsigned datapath: radix-2 shift-add multiply or
// restoring divide, selected by div_mode. Purely combinational.
module alu_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              div_mode,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN:0]     rem_in,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_out,
  output logic [XLEN:0]     rem_out
);

  logic [XLEN:0]   sum;
  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] trial;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide: acc low half shifts dividend bits out and quotient bits in.
  always_comb begin
    sum     = '0;
    shifted = '0;
    trial   = '0;
    acc_out = acc_in;
    rem_out = rem_in;
    if (!div_mode) begin
      sum     = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, opnd} : '0);
      acc_out = {sum, acc_in[XLEN-1:1]};
    end else begin
      shifted = {rem_in, acc_in[XLEN-1]};
      trial   = shifted - {2'b00, opnd};
      if (trial[XLEN+1]) begin
        rem_out = shifted[XLEN:0];
      end else begin
        rem_out = trial[XLEN:0];
      end
      acc_out = {{XLEN{1'b0}}, acc_in[XLEN-2:0], ~trial[XLEN+1]};
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV M-extension unit (MUL*/DIV*/REM*) with valid/ready on both
// sides and a flush input. Operands are converted to magnitudes at
// acceptance; the result sign is applied in a single FIX cycle.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [2:0]      funct3,
  input  logic            abort,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] md_out
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc, acc_step, prod;
  logic [XLEN:0]     rem, rem_step;
  logic [XLEN-1:0]   opnd;
  logic [2:0]        op;
  logic              sign;

  logic              accept, special, signed_a, signed_b, sa, sb;
  logic [XLEN-1:0]   mag_a, mag_b, special_res, fix_res, quo, rmd;
  logic              unused_rem_msb;

  assign unused_rem_msb = rem[XLEN];
  assign accept = in_valid && in_ready && !abort;

  alu_muldiv_step #(.XLEN(XLEN)) u_step (
    .div_mode (is_div(op)),
    .acc_in   (acc),
    .rem_in   (rem),
    .opnd     (opnd),
    .acc_out  (acc_step),
    .rem_out  (rem_step)
  );

  // Operand decode: signedness, magnitudes and early-out results.
  always_comb begin
    signed_a = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
               (funct3 == OP_DIV)  || (funct3 == OP_REM);
    signed_b = (funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM);
    sa       = signed_a && in_a[XLEN-1];
    sb       = signed_b && in_b[XLEN-1];
    mag_a    = sa ? -in_a : in_a;
    mag_b    = sb ? -in_b : in_b;
    special  = is_div(funct3) &&
               ((in_b == '0) || (signed_b && (in_a == MIN_NEG) && (in_b == '1)));
    if (in_b == '0) begin
      special_res = funct3[1] ? in_a : '1;
    end else begin
      special_res = funct3[1] ? '0 : in_a;
    end
  end

  // Sign fix-up and result selection for the FIX cycle.
  always_comb begin
    prod = sign ? -acc : acc;
    quo  = sign ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rmd  = sign ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    case (op)
      OP_MUL:                        fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_res = quo;
      default:                       fix_res = rmd;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = special ? DONE : CALC;
      CALC: if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
    end
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath registers; an abort freezes them, so md_out keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      rem    <= '0;
      opnd   <= '0;
      op     <= '0;
      sign   <= 1'b0;
      md_out <= '0;
    end else if (!abort) begin
      if (accept) begin
        op   <= funct3;
        sign <= (funct3 == OP_REM) ? sa : (sa ^ sb);
        cnt  <= CNT_W'(XLEN);
        rem  <= '0;
        if (is_div(funct3)) begin
          acc  <= {{XLEN{1'b0}}, mag_a};
          opnd <= mag_b;
        end else begin
          acc  <= {{XLEN{1'b0}}, mag_b};
          opnd <= mag_a;
        end
        if (special) begin
          md_out <= special_res;
        end
      end else if (state == CALC) begin
        acc <= acc_step;
        rem <= rem_step;
        cnt <= cnt - CNT_W'(1);
      end else if (state == FIX) begin
        md_out <= fix_res;
      end
    end
  end

endmodule
